rv32i_alu_issue: RTL and testbench

Multi-cycle issue/writeback sequencer that drives the RV32I integer ALU from the instruction side. It accepts one 32-bit OP or OP-IMM instruction per handshake and reads rs1/rs2 from an internal 32x32 register file. It then presents operands and instruction bits [31:12] to the ALU, captures the ALU result, and writes it back to rd. It sits between the fetch/decode front end and the combinational ALU, and is the initiator of the ALU operand interface.

---
 rtl/rv32i_alu_issue.sv | 166 ++++++++++++++++
 tb/tb_rv32i_alu_issue.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_issue.sv
// rv32i_alu_issue: four-state issue/writeback sequencer in front of a
// combinational RV32I ALU. Accepts one OP/OP-IMM word, reads rs1/rs2 from
// the internal register file, drives the ALU from registers, captures the
// result and writes it back to rd. Non-ALU opcodes retire as "illegal".
module rv32i_alu_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] alu_x1,
  output logic [XLEN-1:0] alu_x2,
  output logic [19:0]     alu_instr,
  output logic            alu_cin,
  output logic            alu_opcode_4,
  input  logic [XLEN-1:0] alu_y,
  input  logic            alu_cout,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic [31:0]     retired,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // True for the two opcodes this block knows how to execute (OP, OP-IMM).
  function automatic logic is_alu_op(input logic [6:0] opc);
    return (opc == 7'b0110011) || (opc == 7'b0010011);
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       ir_q;
  logic [XLEN-1:0]   op1_q, op2_q, res_q;
  logic [19:0]       alu_instr_q;
  logic              alu_op4_q;
  logic              wb_valid_q, illegal_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [31:0]       retired_q;
  logic [XLEN-1:0]   regs_q [NREG];

  logic              accept_s;
  logic              legal_s;
  logic [4:0]        rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0]   rd1_s, rd2_s;
  logic              unused_cout_s;

  // alu_cout is reserved; tie it off explicitly so it is visibly consumed.
  assign unused_cout_s = alu_cout;

  assign rs1_s    = ir_q[19:15];
  assign rs2_s    = ir_q[24:20];
  assign rd_s     = ir_q[11:7];
  assign legal_s  = is_alu_op(ir_q[6:0]);
  assign accept_s = instr_valid && (state_q == S_IDLE);

  // Register-file read ports; x0 always reads as zero.
  always_comb begin
    rd1_s    = {XLEN{1'b0}};
    rd2_s    = {XLEN{1'b0}};
    dbg_data = {XLEN{1'b0}};
    if (rs1_s != 5'd0) rd1_s = regs_q[rs1_s];
    else               rd1_s = {XLEN{1'b0}};
    if (rs2_s != 5'd0) rd2_s = regs_q[rs2_s];
    else               rd2_s = {XLEN{1'b0}};
    if (dbg_addr != 5'd0) dbg_data = regs_q[dbg_addr];
    else                  dbg_data = {XLEN{1'b0}};
  end

  // Next-state logic: IDLE waits for a handshake, then a fixed 3-step walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_READ;
        else          state_d = S_IDLE;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: latch word, operands, ALU result, writeback and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q        <= 32'd0;
      op1_q       <= {XLEN{1'b0}};
      op2_q       <= {XLEN{1'b0}};
      res_q       <= {XLEN{1'b0}};
      alu_instr_q <= 20'd0;
      alu_op4_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= {XLEN{1'b0}};
      retired_q   <= 32'd0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) ir_q <= instr;
        end
        S_READ: begin
          // Operand registers double as the ALU drive, so they hold outside EXEC.
          op1_q       <= rd1_s;
          op2_q       <= rd2_s;
          alu_instr_q <= ir_q[31:12];
          alu_op4_q   <= ir_q[5];
        end
        S_EXEC: begin
          res_q      <= alu_y;
          wb_valid_q <= legal_s;
          illegal_q  <= !legal_s;
          if (legal_s) begin
            wb_rd_q   <= rd_s;
            wb_data_q <= alu_y;
          end
        end
        S_WB: begin
          wb_valid_q <= 1'b0;
          illegal_q  <= 1'b0;
          if (legal_s) begin
            retired_q <= retired_q + 32'd1;
            if (rd_s != 5'd0) regs_q[rd_s] <= res_q;
          end
        end
        default: begin
          wb_valid_q <= 1'b0;
          illegal_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign alu_x1       = op1_q;
  assign alu_x2       = op2_q;
  assign alu_instr    = alu_instr_q;
  assign alu_opcode_4 = alu_op4_q;
  assign alu_cin      = 1'b0;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign illegal      = illegal_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Self-checking bench for rv32i_alu_issue: behavioural ALU stub on the
// operand interface plus an ISA-level register-file model as reference.
module tb_rv32i_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_x1, alu_x2, alu_y;
  logic [19:0] alu_instr;
  logic        alu_cin, alu_opcode_4, alu_cout;
  logic        wb_valid, illegal;
  logic [4:0]  wb_rd, dbg_addr;
  logic [31:0] wb_data, retired, dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] regs_m [32];
  logic [31:0] ret_m;

  rv32i_alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_x1(alu_x1), .alu_x2(alu_x2),
    .alu_instr(alu_instr), .alu_cin(alu_cin), .alu_opcode_4(alu_opcode_4),
    .alu_y(alu_y), .alu_cout(alu_cout), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .retired(retired),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stub: works only from the ALU-side fields (instr[31:12] -> alu_instr).
  function automatic logic [31:0] alu_stub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [19:0] f, input logic reg_form);
    logic [31:0] opb;
    logic [4:0]  sh;
    opb = reg_form ? b : {{20{f[19]}}, f[19:8]};
    sh  = opb[4:0];
    case (f[2:0])
      3'd0: return (reg_form && f[18]) ? a - b : a + opb;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
      3'd3: return (a < opb) ? 32'd1 : 32'd0;
      3'd4: return a ^ opb;
      3'd5: return f[18] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | opb;
      default: return a & opb;
    endcase
  endfunction

  always_comb alu_y = alu_stub(alu_x1, alu_x2, alu_instr, alu_opcode_4);
  assign alu_cout = 1'b0;

  // Reference: architectural result of an RV32I OP/OP-IMM word.
  function automatic logic [31:0] ref_result(input logic [31:0] w, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] imm, sum_op;
    logic        is_reg;
    int          sh;
    is_reg = (w[6:0] == 7'b0110011);
    imm    = {{20{w[31]}}, w[31:20]};
    sum_op = is_reg ? b : imm;
    sh     = is_reg ? int'(b % 32) : int'(w[24:20]);
    case (w[14:12])
      3'd0: return (is_reg && w[30]) ? a - b : a + sum_op;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(sum_op)) ? 32'd1 : 32'd0;
      3'd3: return (a < sum_op) ? 32'd1 : 32'd0;
      3'd4: return a ^ sum_op;
      3'd5: return w[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | sum_op;
      default: return a & sum_op;
    endcase
  endfunction

  // Apply one word to the architectural model.
  task automatic model_apply(input logic [31:0] w, output bit legal,
                             output logic [4:0] rd, output logic [31:0] data);
    legal = (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011);
    rd    = w[11:7];
    data  = ref_result(w, regs_m[w[19:15]], regs_m[w[24:20]]);
    if (legal) begin
      if (rd != 5'd0) regs_m[rd] = data;
      ret_m = ret_m + 32'd1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
    ret_m = 32'd0;
  endtask

  // Read the debug port between edges.
  task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Return at a falling edge with instr_ready high; bounded.
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = instr_ready;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_ready: instr_ready=%b required 1 within 20 cycles", instr_ready);
    end
  endtask

  // Issue one word and observe 4 cycles after the accept edge.
  task automatic run_instr(input logic [31:0] w, output int ev_k, output int nwb,
                           output int nill, output logic [4:0] rd_o, output logic [31:0] data_o);
    wait_ready();
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    ev_k = 0; nwb = 0; nill = 0; rd_o = 5'd0; data_o = 32'd0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (wb_valid) nwb++;
      if (illegal) nill++;
      if ((wb_valid || illegal) && ev_k == 0) begin
        ev_k = k; rd_o = wb_rd; data_o = wb_data;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    checks++; if (wb_valid !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_pulses: wb_valid=%b illegal=%b want 0 0", wb_valid, illegal); end
    checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired: got %h want 0", retired); end
    checks++; if (alu_x1 !== 32'd0 || alu_x2 !== 32'd0 || alu_instr !== 20'd0 || alu_opcode_4 !== 1'b0 || alu_cin !== 1'b0) begin
      failures++; $display("FAIL reset_alu: x1=%h x2=%h instr=%h op4=%b cin=%b want all 0", alu_x1, alu_x2, alu_instr, alu_opcode_4, alu_cin); end
    checks++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin failures++; $display("FAIL reset_wb: rd=%0d data=%h want 0 0", wb_rd, wb_data); end
    for (int i = 0; i < 32; i++) begin
      dbg_read(5'(i), d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_reg x%0d: got %h want 0", i, d); end
    end
  endtask

  task automatic test_first_addi();
    int k, nw, ni; logic [4:0] r; logic [31:0] v, d; bit lg; logic [4:0] er; logic [31:0] ev;
    run_instr(32'h0050_0093, k, nw, ni, r, v);
    model_apply(32'h0050_0093, lg, er, ev);
    checks++; if (k != 3 || nw != 1 || ni != 0) begin failures++; $display("FAIL addi_latency: event_cycle=%0d wb=%0d ill=%0d want 3 1 0", k, nw, ni); end
    checks++; if (r !== 5'd1 || v !== 32'd5) begin failures++; $display("FAIL addi_wb: rd=%0d data=%h want 1 5", r, v); end
    dbg_read(5'd1, d);
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL addi_dbg_x1: got %h want 5", d); end
    checks++; if (retired !== 32'd1) begin failures++; $display("FAIL addi_retired: got %0d want 1", retired); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'hFFD0_0113, 32'h0020_81B3, 32'h4020_8233};
    logic [31:0] exp_q [$];
    logic [4:0]  rq [$];
    bit lg; logic [4:0] er; logic [31:0] ev, d;
    int idx = 0, nready = 0, nwb = 0;
    bit rdy;
    for (int i = 0; i < 3; i++) begin
      model_apply(words[i], lg, er, ev);
      exp_q.push_back(ev); rq.push_back(er);
    end
    wait_ready();
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (idx < 3) begin instr_valid = 1'b1; instr = words[idx]; end
      else instr_valid = 1'b0;
      rdy = instr_ready;
      if (cyc < 12 && rdy) nready++;
      if (wb_valid) begin
        nwb++;
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front(); er = rq.pop_front();
          checks++; if (wb_data !== ev || wb_rd !== er) begin failures++; $display("FAIL b2b_wb: rd=%0d data=%h want %0d %h", wb_rd, wb_data, er, ev); end
        end
      end
      @(posedge clk);
      if (rdy && idx < 3) idx++;
    end
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (nready != 3 || idx != 3) begin failures++; $display("FAIL b2b_ready_ratio: ready_cycles=%0d accepted=%0d want 3 3", nready, idx); end
    checks++; if (nwb != 3) begin failures++; $display("FAIL b2b_wb_count: got %0d want 3", nwb); end
    dbg_read(5'd2, d);
    checks++; if (d !== 32'hFFFF_FFFD) begin failures++; $display("FAIL b2b_x2: got %h want fffffffd", d); end
    dbg_read(5'd3, d);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL b2b_x3: got %h want 2", d); end
    dbg_read(5'd4, d);
    checks++; if (d !== 32'd8) begin failures++; $display("FAIL b2b_x4: got %h want 8", d); end
    checks++; if (retired !== 32'd4) begin failures++; $display("FAIL b2b_retired: got %0d want 4", retired); end
  endtask

  task automatic test_x0_write();
    int k, nw, ni; logic [4:0] r; logic [31:0] v, d; bit lg; logic [4:0] er; logic [31:0] ev;
    run_instr(32'h0070_0013, k, nw, ni, r, v);
    model_apply(32'h0070_0013, lg, er, ev);
    checks++; if (nw != 1 || r !== 5'd0 || v !== 32'd7) begin failures++; $display("FAIL x0_wb: wb=%0d rd=%0d data=%h want 1 0 7", nw, r, v); end
    dbg_read(5'd0, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL x0_dbg: got %h want 0", d); end
    checks++; if (retired !== ret_m) begin failures++; $display("FAIL x0_retired: got %0d want %0d", retired, ret_m); end
  endtask

  task automatic test_illegal();
    int k, nw, ni; logic [4:0] r; logic [31:0] v, d; bit lg; logic [4:0] er; logic [31:0] ev;
    run_instr(32'h0000_10B7, k, nw, ni, r, v);
    model_apply(32'h0000_10B7, lg, er, ev);
    checks++; if (k != 3 || ni != 1 || nw != 0) begin failures++; $display("FAIL lui_illegal: event_cycle=%0d ill=%0d wb=%0d want 3 1 0", k, ni, nw); end
    dbg_read(5'd1, d);
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL lui_x1_kept: got %h want 5", d); end
    checks++; if (retired !== ret_m) begin failures++; $display("FAIL lui_retired: got %0d want %0d", retired, ret_m); end
  endtask

  // Random legal/illegal word; registers limited to x0..x7 for dependencies.
  function automatic logic [31:0] rand_word();
    logic [6:0]  bad_ops [4] = '{7'b0110111, 7'b0000011, 7'b1101111, 7'b0100011};
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] raw;
    int kind;
    kind = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    raw = $urandom;
    if (kind <= 4) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && raw[0]) ? 7'b0100000 : 7'b0000000;
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
    end else if (kind <= 8) begin
      imm = raw[31:20];
      if (f3 == 3'd1) imm = {7'b0000000, sh};
      if (f3 == 3'd5) imm = {(raw[0] ? 7'b0100000 : 7'b0000000), sh};
      return {imm, rs1, f3, rd, 7'b0010011};
    end else begin
      return {raw[31:7], bad_ops[raw[1:0]]};
    end
  endfunction

  task automatic test_random();
    int k, nw, ni; logic [4:0] r; logic [31:0] v, d, w; bit lg; logic [4:0] er; logic [31:0] ev;
    for (int n = 0; n < 40; n++) begin
      w = rand_word();
      run_instr(w, k, nw, ni, r, v);
      model_apply(w, lg, er, ev);
      checks++;
      if (lg && (k != 3 || nw != 1 || ni != 0 || r !== er || v !== ev)) begin
        failures++; $display("FAIL rand_legal %h: cyc=%0d wb=%0d ill=%0d rd=%0d data=%h want 3 1 0 %0d %h", w, k, nw, ni, r, v, er, ev);
      end else if (!lg && (k != 3 || nw != 0 || ni != 1)) begin
        failures++; $display("FAIL rand_illegal %h: cyc=%0d wb=%0d ill=%0d want 3 0 1", w, k, nw, ni);
      end
      checks++; if (retired !== ret_m) begin failures++; $display("FAIL rand_retired: got %0d want %0d", retired, ret_m); end
    end
    for (int i = 0; i < 8; i++) begin
      dbg_read(5'(i), d);
      checks++; if (d !== regs_m[i]) begin failures++; $display("FAIL rand_reg x%0d: got %h want %h", i, d, regs_m[i]); end
    end
  endtask

  task automatic test_wrap();
    int k, nw, ni; logic [4:0] r; logic [31:0] v; bit lg; logic [4:0] er; logic [31:0] ev;
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    ret_m = 32'hFFFF_FFFE;
    run_instr(32'h0010_0313, k, nw, ni, r, v);
    model_apply(32'h0010_0313, lg, er, ev);
    checks++; if (retired !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_ffff: got %h want ffffffff", retired); end
    run_instr(32'h0010_0313, k, nw, ni, r, v);
    model_apply(32'h0010_0313, lg, er, ev);
    checks++; if (retired !== 32'd0 || ret_m !== 32'd0) begin failures++; $display("FAIL wrap_zero: got %h want 0", retired); end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] d; int nw = 0;
    wait_ready();
    instr = 32'h0090_0293; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);   // READ
    @(negedge clk);   // EXEC
    checks++; if (alu_instr !== 20'h00900 || alu_opcode_4 !== 1'b0 || alu_x1 !== 32'd0) begin
      failures++; $display("FAIL exec_drive: instr=%h op4=%b x1=%h want 00900 0 0", alu_instr, alu_opcode_4, alu_x1); end
    rst = 1'b1;
    @(negedge clk);
    if (wb_valid) nw++;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", instr_ready); end
    for (int i = 0; i < 4; i++) begin
      if (wb_valid || illegal) nw++;
      @(negedge clk);
    end
    checks++; if (nw != 0) begin failures++; $display("FAIL rst_mid_no_wb: pulses=%0d want 0", nw); end
    dbg_read(5'd5, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_mid_x5: got %h want 0", d); end
    dbg_read(5'd1, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_mid_x1_cleared: got %h want 0", d); end
    checks++; if (retired !== 32'd0) begin failures++; $display("FAIL rst_mid_retired: got %0d want 0", retired); end
  endtask

  initial begin
    test_reset();
    test_first_addi();
    test_back_to_back();
    test_x0_write();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded 500000");
    $fatal(1);
  end

endmodule
